// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bundle: ROM address/data, decoder feedback and execute-stage controls.
// Latency: none, signal bundle only.
// Backpressure: none; pacing comes from the tick clock enable.
interface fetch_sequencer_if;
  logic        tick;
  logic [12:0] rom_addr;
  logic [11:0] rom_data;
  logic [11:0] opcode;
  logic [1:0]  cycle_length;
  logic        skip_pc_increment;
  logic        pc_load;
  logic [12:0] pc_load_value;
  logic        halt;
  logic [12:0] pc;
  logic [3:0]  cycle_count;
  logic        instr_start;
  logic        halted;

  // Sequencer side
  modport master (
    input  tick, rom_data, cycle_length, skip_pc_increment, pc_load, pc_load_value, halt,
    output rom_addr, opcode, pc, cycle_count, instr_start, halted
  );

  // ROM / decoder / execute side
  modport slave (
    output tick, rom_data, cycle_length, skip_pc_increment, pc_load, pc_load_value, halt,
    input  rom_addr, opcode, pc, cycle_count, instr_start, halted
  );
endinterface

// File: rtl/fetch_sequencer.sv
// E0C6S46 instruction fetch and cycle sequencer: owns the PC, latches opcodes, counts 5/7/12 ticks.
// Latency: opcode/instr_start update on the fetch tick edge; rom_addr follows pc combinationally.
// Backpressure: none; halt holds the sequencer at the last tick until a tick arrives with halt low.
module fetch_sequencer #(
  parameter logic [12:0] RESET_PC     = 13'h0100,
  parameter logic [11:0] RESET_OPCODE = 12'hFFB
) (
  input  logic              clk,
  input  logic              reset_n,
  fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    ST_PRIME  = 2'd0,
    ST_EXEC   = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [12:0] pc_q, pc_d;
  logic [11:0] opcode_q, opcode_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        start_q, start_d;
  logic [1:0]  prime_q, prime_d;
  logic [3:0]  last_cnt;
  logic        fetch;

  // Index of the final tick: CYCLE5=00, CYCLE7=01, CYCLE12=10; 11 falls back to 5 ticks
  always_comb begin
    last_cnt = 4'd4;
    case (bus.cycle_length)
      2'b01:   last_cnt = 4'd6;
      2'b10:   last_cnt = 4'd11;
      default: last_cnt = 4'd4;
    endcase
  end

  // Next-state and datapath decisions, all taken on tick
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    opcode_d = opcode_q;
    cnt_d    = cnt_q;
    start_d  = 1'b0;
    prime_d  = (prime_q == 2'd2) ? prime_q : prime_q + 2'd1;
    fetch    = 1'b0;

    case (state_q)
      ST_PRIME: begin
        // Ticks are ignored until the ROM has had two clocks to present RESET_PC
        if (bus.tick && prime_q == 2'd2) begin
          fetch   = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (bus.tick) begin
          // The tick at count 0 never writes the PC; a load beats the increment
          if (cnt_q != 4'd0) begin
            if (bus.pc_load) begin
              pc_d = bus.pc_load_value;
            end else if (cnt_q == 4'd1 && !bus.skip_pc_increment) begin
              // Step wraps inside the page: bank and page bits are untouched
              pc_d = {pc_q[12:8], pc_q[7:0] + 8'd1};
            end
          end
          if (cnt_q >= last_cnt) begin
            if (bus.halt) begin
              state_d = ST_HALTED;
            end else begin
              fetch = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      ST_HALTED: begin
        if (bus.tick && !bus.halt) begin
          fetch   = 1'b1;
          state_d = ST_EXEC;
        end
      end
      default: state_d = ST_PRIME;
    endcase

    if (fetch) begin
      opcode_d = bus.rom_data;
      cnt_d    = 4'd0;
      start_d  = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_PRIME;
    end else begin
      state_q <= state_d;
    end
  end

  // PC, opcode, tick counter, start pulse and prime counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q     <= RESET_PC;
      opcode_q <= RESET_OPCODE;
      cnt_q    <= 4'd0;
      start_q  <= 1'b0;
      prime_q  <= 2'd0;
    end else begin
      pc_q     <= pc_d;
      opcode_q <= opcode_d;
      cnt_q    <= cnt_d;
      start_q  <= start_d;
      prime_q  <= prime_d;
    end
  end

  assign bus.rom_addr    = pc_q;
  assign bus.pc          = pc_q;
  assign bus.opcode      = opcode_q;
  assign bus.cycle_count = cnt_q;
  assign bus.instr_start = start_q;
  assign bus.halted      = (state_q == ST_HALTED);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: synchronous ROM, opcode decoder and an instruction-level reference model.
// Latency: model tracks ticks since the last fetch and derives count/halted from it.
// Backpressure: n/a; ticks every 3 clk, halt driven as a level.
module tb_fetch_sequencer;
  localparam logic [12:0] RST_PC = 13'h0100;
  localparam logic [11:0] RST_OP = 12'hFFB;

  logic clk = 1'b0;
  logic reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  fetch_sequencer_if u_if ();

  fetch_sequencer #(.RESET_PC(RST_PC), .RESET_OPCODE(RST_OP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (u_if.master)
  );

  always #5 clk = ~clk;

  // Program ROM with one clock of read latency
  logic [11:0] rom [0:8191];
  always @(posedge clk) u_if.rom_data <= rom[u_if.rom_addr];

  // Bench decoder: 9xx CYCLE7, 4xx CALL (CYCLE7, skip), Axx CYCLE12, Bxx length code 11, else CYCLE5
  function automatic logic [1:0] dec_len(input logic [11:0] op);
    case (op[11:8])
      4'h4, 4'h9: return 2'b01;
      4'hA:       return 2'b10;
      4'hB:       return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

  function automatic logic dec_skip(input logic [11:0] op);
    return op[11:8] == 4'h4;
  endfunction

  function automatic int n_of(input logic [11:0] op);
    case (dec_len(op))
      2'b01:   return 7;
      2'b10:   return 12;
      default: return 5;
    endcase
  endfunction

  assign u_if.cycle_length      = dec_len(u_if.opcode);
  assign u_if.skip_pc_increment = dec_skip(u_if.opcode);

  // Reference model: m_idx = ticks since the last fetch; reaching N means parked by halt
  logic [12:0] m_pc;
  logic [11:0] m_op;
  int          m_idx;
  bit          m_run;
  int          m_clks;
  bit          m_start;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pc    <= RST_PC;
      m_op    <= RST_OP;
      m_idx   <= 0;
      m_run   <= 1'b0;
      m_clks  <= 0;
      m_start <= 1'b0;
    end else begin
      m_start <= 1'b0;
      if (m_clks < 2) m_clks <= m_clks + 1;
      if (u_if.tick) begin
        if (!m_run) begin
          if (m_clks >= 2) begin
            m_op <= rom[m_pc]; m_idx <= 0; m_start <= 1'b1; m_run <= 1'b1;
          end
        end else if (m_idx < n_of(m_op) - 1) begin
          if (m_idx >= 1 && u_if.pc_load) m_pc <= u_if.pc_load_value;
          else if (m_idx == 1 && !dec_skip(m_op)) m_pc <= {m_pc[12:8], m_pc[7:0] + 8'd1};
          m_idx <= m_idx + 1;
        end else if (m_idx == n_of(m_op) - 1) begin
          if (u_if.pc_load) m_pc <= u_if.pc_load_value;
          if (u_if.halt) begin
            m_idx <= m_idx + 1;
          end else begin
            m_op <= rom[m_pc]; m_idx <= 0; m_start <= 1'b1;
          end
        end else if (!u_if.halt) begin
          m_op <= rom[m_pc]; m_idx <= 0; m_start <= 1'b1;
        end
      end
    end
  end

  function automatic logic [3:0] exp_cnt();
    int lim = n_of(m_op) - 1;
    return 4'((m_idx > lim) ? lim : m_idx);
  endfunction

  function automatic logic exp_halted();
    return m_run && (m_idx >= n_of(m_op));
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    check("pc",          16'(u_if.pc),          16'(m_pc));
    check("rom_addr",    16'(u_if.rom_addr),    16'(m_pc));
    check("opcode",      16'(u_if.opcode),      16'(m_op));
    check("cycle_count", 16'(u_if.cycle_count), 16'(exp_cnt()));
    check("instr_start", 16'(u_if.instr_start), 16'(m_start));
    check("halted",      16'(u_if.halted),      16'(exp_halted()));
  endtask

  task automatic step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic tick_edge();
    u_if.tick = 1'b1;
    step();
    u_if.tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick_edge();
      step();
      step();
    end
  endtask

  task automatic load_tick(input logic [12:0] v);
    u_if.pc_load       = 1'b1;
    u_if.pc_load_value = v;
    tick_edge();
    u_if.pc_load = 1'b0;
    step();
    step();
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) rom[i] = 12'h000;
    rom[13'h100] = 12'h812;
    rom[13'h101] = 12'h000;
    rom[13'h1FF] = 12'h9C0;
    rom[13'h120] = 12'h4A0;
    rom[13'h1A0] = 12'hA55;
    rom[13'h130] = 12'hB00;
    rom[13'h131] = 12'h812;

    reset_n            = 1'b0;
    u_if.tick          = 1'b0;
    u_if.pc_load       = 1'b0;
    u_if.pc_load_value = 13'h0;
    u_if.halt          = 1'b0;

    // Reset values
    repeat (3) step();
    check("rst_pc", 16'(u_if.pc), 16'h0100);
    check("rst_opcode", 16'(u_if.opcode), 16'h0FFB);
    check("rst_cnt", 16'(u_if.cycle_count), 16'h0);
    check("rst_halted", 16'(u_if.halted), 16'h0);
    check("rst_start", 16'(u_if.instr_start), 16'h0);

    // Tick one clock after release is ignored; the next one fetches from 0x100
    reset_n = 1'b1;
    step();
    u_if.tick = 1'b1;
    step();
    u_if.tick = 1'b0;
    check("prime_ignore_op", 16'(u_if.opcode), 16'h0FFB);
    check("prime_ignore_start", 16'(u_if.instr_start), 16'h0);
    step();
    tick_edge();
    check("first_fetch_op", 16'(u_if.opcode), 16'h0812);
    check("first_fetch_pc", 16'(u_if.pc), 16'h0100);
    check("first_fetch_start", 16'(u_if.instr_start), 16'h1);
    step();
    check("start_drop", 16'(u_if.instr_start), 16'h0);
    step();

    // Straight-line CYCLE5: increment on the count-1 tick, fetch on the 5th tick
    ticks(1);
    check("tick0_pc", 16'(u_if.pc), 16'h0100);
    ticks(1);
    check("tick1_pc", 16'(u_if.pc), 16'h0101);
    ticks(2);
    check("last_cnt5", 16'(u_if.cycle_count), 16'h4);
    tick_edge();
    check("fetch_101", 16'(u_if.opcode), 16'h0000);
    check("fetch_101_cnt", 16'(u_if.cycle_count), 16'h0);
    step(); step();

    // Load on count 0 is ignored; load on count 1 wins over the increment
    load_tick(13'h0055);
    check("load_cnt0_ignored", 16'(u_if.pc), 16'h0101);
    load_tick(13'h01FF);
    check("load_cnt1", 16'(u_if.pc), 16'h01FF);
    ticks(2);
    tick_edge();
    check("fetch_1ff", 16'(u_if.opcode), 16'h09C0);
    step(); step();

    // CYCLE7 at 0x1FF: step wraps to 0x00 within page 1
    ticks(2);
    check("step_wrap", 16'(u_if.pc), 16'h0100);
    ticks(4);
    check("cyc7_hold_op", 16'(u_if.opcode), 16'h09C0);
    check("cyc7_last_cnt", 16'(u_if.cycle_count), 16'h6);
    tick_edge();
    check("fetch_after_wrap", 16'(u_if.opcode), 16'h0812);
    step(); step();

    // Jump to the CALL at 0x120
    ticks(2);
    load_tick(13'h0120);
    ticks(1);
    tick_edge();
    check("fetch_call", 16'(u_if.opcode), 16'h04A0);
    step(); step();

    // CALL: no increment; load on the final tick lands in pc
    ticks(2);
    check("call_no_inc", 16'(u_if.pc), 16'h0120);
    ticks(4);
    u_if.pc_load       = 1'b1;
    u_if.pc_load_value = 13'h01A0;
    tick_edge();
    u_if.pc_load = 1'b0;
    check("call_final_load", 16'(u_if.pc), 16'h01A0);
    check("call_final_start", 16'(u_if.instr_start), 16'h1);
    step(); step();
    ticks(6);
    tick_edge();
    check("fetch_1a0", 16'(u_if.opcode), 16'h0A55);
    step(); step();

    // CYCLE12 with a jump to 0x130 on count 2
    ticks(2);
    check("cyc12_inc", 16'(u_if.pc), 16'h01A1);
    load_tick(13'h0130);
    ticks(8);
    check("cyc12_last_cnt", 16'(u_if.cycle_count), 16'hB);
    tick_edge();
    check("fetch_130", 16'(u_if.opcode), 16'h0B00);
    step(); step();

    // Length code 11 runs as 5 ticks; halt on its final tick
    ticks(4);
    u_if.halt = 1'b1;
    ticks(1);
    check("halt_enter", 16'(u_if.halted), 16'h1);
    check("halt_cnt", 16'(u_if.cycle_count), 16'h4);
    ticks(10);
    check("halt_hold_op", 16'(u_if.opcode), 16'h0B00);
    check("halt_hold_cnt", 16'(u_if.cycle_count), 16'h4);
    u_if.halt = 1'b0;
    tick_edge();
    check("wake_op", 16'(u_if.opcode), 16'h0812);
    check("wake_start", 16'(u_if.instr_start), 16'h1);
    check("wake_halted", 16'(u_if.halted), 16'h0);
    step(); step();

    // Halt again, then reset mid-clock while halted
    ticks(4);
    u_if.halt = 1'b1;
    ticks(1);
    check("halt2", 16'(u_if.halted), 16'h1);
    #2 reset_n = 1'b0;
    #1;
    compare_all();
    check("async_rst_pc", 16'(u_if.pc), 16'h0100);
    check("async_rst_halted", 16'(u_if.halted), 16'h0);
    check("async_rst_op", 16'(u_if.opcode), 16'h0FFB);
    u_if.halt = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step(); step();
    tick_edge();
    check("refetch_op", 16'(u_if.opcode), 16'h0812);
    check("refetch_start", 16'(u_if.instr_start), 16'h1);
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
